// File: rtl/ctrl_mem_arb_if.sv
// Client request/response and byte-wide RAM port bundle for ctrl_mem_arb.
// Latency: none, this is a wiring bundle only.
// Backpressure: clients hold req_valid until resp_done; the RAM port has no stall.
interface ctrl_mem_arb_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_write;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*32-1:0]     req_wdata;
  logic [NUM_CH*3-1:0]      req_len;
  logic [NUM_CH-1:0]        req_signed;
  logic [NUM_CH-1:0]        grant;
  logic [NUM_CH-1:0]        resp_done;
  logic [31:0]              resp_data;
  logic                     resp_err;
  logic                     busy;
  logic                     ram_rw;
  logic [ADDR_W-1:0]        ram_addr;
  logic [7:0]               ram_w_data;
  logic [7:0]               ram_r_data;

  // Controller side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_len, req_signed, ram_r_data,
    output grant, resp_done, resp_data, resp_err, busy, ram_rw, ram_addr, ram_w_data
  );

  // Clients plus RAM side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_len, req_signed, ram_r_data,
    input  grant, resp_done, resp_data, resp_err, busy, ram_rw, ram_addr, ram_w_data
  );
endinterface

// File: rtl/ctrl_mem_arb.sv
// Arbitrates NUM_CH clients onto one byte-wide sync RAM; 1/2/4-byte reads/writes, reads pipelined.
// Latency: grant edge to done pulse is L+1 cycles (write), L+2 (read), 1 (illegal length).
// Backpressure: requests are held until resp_done; losers wait. CTRL_MEM_RR_EN selects round-robin, else fixed priority.
module ctrl_mem_arb #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  ctrl_mem_arb_if.slave bus
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [IDX_W-1:0]  win_idx;
  logic              any_req;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [2:0]        win_len;
  logic              win_legal;

  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_full;
  logic [DATA_W-1:0] rd_ext;
  logic [2:0]        len_q;
  logic [2:0]        cnt_q;
  logic              sgn_q;
  logic              wr_q;
  logic              run_last;
  logic [1:0]        wr_byte;
  logic [1:0]        rd_byte;

  logic [NUM_CH-1:0] grant_q;
  logic [NUM_CH-1:0] done_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              err_q;
  logic              ram_rw_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_w_data_q;

`ifdef CTRL_MEM_RR_EN
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] rr_idx;

  // Round-robin pick: nearest requester after the previous winner, wrapping.
  always_comb begin
    win_idx = last_q;
    rr_idx  = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      rr_idx = IDX_W'((int'(last_q) + i) % NUM_CH);
      if (bus.req_valid[rr_idx]) win_idx = rr_idx;
    end
  end

  // Remember every winner, error grants included.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= IDX_W'(NUM_CH - 1);
    else if (state_q == IDLE && any_req) last_q <= win_idx;
  end
`else
  // Fixed priority pick: lowest requesting index wins.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) win_idx = IDX_W'(i);
    end
  end
`endif

  assign any_req   = |bus.req_valid;
  assign win_addr  = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_wdata = bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
  assign win_len   = bus.req_len[int'(win_idx)*3 +: 3];
  assign win_legal = (win_len == 3'd1) || (win_len == 3'd2) || (win_len == 3'd4);

  // Writes end on the edge after the last byte issue; reads one edge later to catch the last byte.
  assign run_last = wr_q ? (cnt_q == len_q) : (cnt_q == len_q + 3'd1);
  assign wr_byte  = cnt_q[1:0];
  assign rd_byte  = cnt_q[1:0] - 2'd2;

  // Merge the live RAM byte as the top byte, then sign/zero extend by length.
  always_comb begin
    rd_full = rdata_q;
    case (len_q)
      3'd1:    rd_full[7:0]   = bus.ram_r_data;
      3'd2:    rd_full[15:8]  = bus.ram_r_data;
      default: rd_full[31:24] = bus.ram_r_data;
    endcase
    case (len_q)
      3'd1:    rd_ext = {{24{sgn_q & rd_full[7]}}, rd_full[7:0]};
      3'd2:    rd_ext = {{16{sgn_q & rd_full[15]}}, rd_full[15:0]};
      default: rd_ext = rd_full;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: illegal lengths skip RUN and complete straight away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = win_legal ? RUN : DONE;
      RUN:     if (run_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner, drive the RAM port byte by byte, collect read bytes, pulse completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_q      <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      resp_data_q  <= '0;
      ram_rw_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_w_data_q <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      sgn_q        <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= NUM_CH'(1) << win_idx;
            base_q  <= win_addr;
            wdata_q <= win_wdata;
            len_q   <= win_len;
            sgn_q   <= bus.req_signed[win_idx];
            wr_q    <= bus.req_write[win_idx];
            rdata_q <= '0;
            cnt_q   <= 3'd1;
            if (win_legal) begin
              ram_rw_q     <= bus.req_write[win_idx];
              ram_addr_q   <= win_addr;
              ram_w_data_q <= win_wdata[7:0];
            end else begin
              done_q      <= NUM_CH'(1) << win_idx;
              err_q       <= 1'b1;
              resp_data_q <= '0;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q < len_q) begin
            ram_rw_q     <= wr_q;
            ram_addr_q   <= base_q + ADDR_W'(cnt_q);
            ram_w_data_q <= wdata_q[{wr_byte, 3'b000} +: 8];
          end else begin
            ram_rw_q <= 1'b0;
          end
          if (!wr_q && !run_last && cnt_q >= 3'd2) rdata_q[{rd_byte, 3'b000} +: 8] <= bus.ram_r_data;
          if (run_last) begin
            done_q      <= grant_q;
            resp_data_q <= wr_q ? '0 : rd_ext;
          end
        end
        DONE: begin
          grant_q  <= '0;
          ram_rw_q <= 1'b0;
          cnt_q    <= '0;
        end
        default: begin
          grant_q  <= '0;
          ram_rw_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.resp_done  = done_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.ram_rw     = ram_rw_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_w_data = ram_w_data_q;
endmodule

// File: tb/tb_ctrl_mem_arb.sv
// Directed bench for ctrl_mem_arb with a byte-wide synchronous RAM model.
// Latency: measured from the grant edge (cycle 1 = cycle after grant latch) to the done pulse.
// Backpressure: clients hold req_valid until they see resp_done, then drop it.
module tb_ctrl_mem_arb;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ctrl_mem_arb_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  ctrl_mem_arb #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // RAM model: one-cycle read latency, preload port for initial contents.
  logic [7:0]  mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_a;
  logic [7:0]  pl_d;
  always @(posedge clock) begin
    if (pl_en)           mem[pl_a] <= pl_d;
    else if (bus.ram_rw) mem[bus.ram_addr[11:0]] <= bus.ram_w_data;
    bus.ram_r_data <= mem[bus.ram_addr[11:0]];
  end

  // Per-transaction observations.
  logic [1:0]  o_grant, o_done, o_exp_g;
  logic [31:0] o_data;
  logic        o_err;
  int          o_lat, o_gwait, rw_cnt;
  logic        tr_rw   [0:9];
  logic [31:0] tr_addr [0:9];
  logic [7:0]  tr_wd   [0:9];
  logic [1:0]  exp_g   [0:3];
  logic [31:0] exp_d;
  logic [1:0]  done_acc;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_req(input int ch, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] len, input bit sg);
    bus.req_write[ch]                  = wr;
    bus.req_addr[ch*ADDR_W +: ADDR_W]  = a;
    bus.req_wdata[ch*32 +: 32]         = wd;
    bus.req_len[ch*3 +: 3]             = len;
    bus.req_signed[ch]                 = sg;
    bus.req_valid[ch]                  = 1'b1;
  endtask

  // Wait (bounded) for a done pulse, recording the RAM port cycle by cycle from the grant.
  task automatic wait_done(input bit rearm);
    bit         seen_g;
    bit         got;
    int         cyc;
    logic [1:0] dch;
    seen_g = 0; got = 0; cyc = 0; rw_cnt = 0; o_gwait = 0;
    o_grant = '0; o_done = '0; o_data = '0; o_err = 1'b0; o_lat = 0;
    for (int i = 0; i < 10; i++) begin
      tr_rw[i] = 1'b0; tr_addr[i] = '0; tr_wd[i] = '0;
    end
    for (int t = 1; t <= 40 && !got; t++) begin
      tick();
      if (!seen_g && bus.grant != '0) begin
        seen_g = 1; o_grant = bus.grant; o_gwait = t;
      end
      if (seen_g) begin
        cyc++;
        if (cyc < 10) begin
          tr_rw[cyc] = bus.ram_rw; tr_addr[cyc] = bus.ram_addr; tr_wd[cyc] = bus.ram_w_data;
        end
        if (bus.ram_rw) rw_cnt++;
      end
      if (bus.resp_done != '0) begin
        got = 1; o_done = bus.resp_done; o_data = bus.resp_data; o_err = bus.resp_err; o_lat = cyc;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    dch = o_done;
    bus.req_valid = bus.req_valid & ~dch;
    tick();
    chk("idle_after_done", {bus.busy, bus.grant, bus.resp_done}, 64'd0);
    if (rearm) bus.req_valid = bus.req_valid | dch;
  endtask

  initial begin
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_len = '0; bus.req_signed = '0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    #1 reset = 1'b0;

    // Preload RAM while held in reset.
    poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    poke(12'h020, 8'h80); poke(12'h030, 8'h01); poke(12'h031, 8'h80);
    poke(12'h040, 8'h5A); poke(12'h050, 8'hC3);

    // Reset state.
    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.resp_done, 0);
    chk("rst_err", bus.resp_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ram_rw", bus.ram_rw, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wd", bus.ram_w_data, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    reset = 1'b1;
    tick();

    // Ch1 read, 4 bytes at 0x100.
    set_req(1, 1'b0, 32'h100, 32'h0, 3'd4, 1'b0);
    wait_done(1'b0);
    chk("rd4_grant", o_grant, 2'b10);
    chk("rd4_grant_edge", o_gwait, 1);
    chk("rd4_done", o_done, 2'b10);
    chk("rd4_data", o_data, 32'h44332211);
    chk("rd4_err", o_err, 0);
    chk("rd4_lat", o_lat, 6);
    for (int k = 1; k <= 4; k++) chk("rd4_addr_seq", tr_addr[k], 32'h100 + 32'(k - 1));
    chk("rd4_no_write", rw_cnt, 0);

    // Ch0 single byte, signed then unsigned; then signed halfword.
    set_req(0, 1'b0, 32'h20, 32'h0, 3'd1, 1'b1);
    wait_done(1'b0);
    chk("rd1s_data", o_data, 32'hFFFFFF80);
    chk("rd1s_lat", o_lat, 3);
    set_req(0, 1'b0, 32'h20, 32'h0, 3'd1, 1'b0);
    wait_done(1'b0);
    chk("rd1u_data", o_data, 32'h00000080);
    set_req(0, 1'b0, 32'h30, 32'h0, 3'd2, 1'b1);
    wait_done(1'b0);
    chk("rd2s_data", o_data, 32'hFFFF8001);
    chk("rd2s_lat", o_lat, 4);

    // Ch0 halfword write at 0x3FE, then read it back.
    set_req(0, 1'b1, 32'h3FE, 32'hA5B6C7D8, 3'd2, 1'b0);
    wait_done(1'b0);
    chk("wr2_done", o_done, 2'b01);
    chk("wr2_lat", o_lat, 3);
    chk("wr2_rw_cycles", rw_cnt, 2);
    chk("wr2_rw1", tr_rw[1], 1);
    chk("wr2_addr1", tr_addr[1], 32'h3FE);
    chk("wr2_wd1", tr_wd[1], 8'hD8);
    chk("wr2_addr2", tr_addr[2], 32'h3FF);
    chk("wr2_wd2", tr_wd[2], 8'hC7);
    chk("wr2_rw3", tr_rw[3], 0);
    set_req(0, 1'b0, 32'h3FE, 32'h0, 3'd2, 1'b0);
    wait_done(1'b0);
    chk("wr2_readback", o_data, 32'h0000C7D8);

    // Illegal length on ch1.
    set_req(1, 1'b0, 32'h60, 32'h0, 3'd3, 1'b0);
    wait_done(1'b0);
    chk("bad_grant", o_grant, 2'b10);
    chk("bad_done", o_done, 2'b10);
    chk("bad_err", o_err, 1);
    chk("bad_data", o_data, 0);
    chk("bad_lat", o_lat, 1);
    chk("bad_no_ram", rw_cnt, 0);

    // Both channels contend four times.
`ifdef CTRL_MEM_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    set_req(0, 1'b0, 32'h40, 32'h0, 3'd1, 1'b0);
    set_req(1, 1'b0, 32'h50, 32'h0, 3'd1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      wait_done(r < 3);
      o_exp_g = exp_g[r];
      exp_d = (o_exp_g == 2'b01) ? 32'h5A : 32'hC3;
      chk("arb_grant", o_grant, o_exp_g);
      chk("arb_data", o_data, exp_d);
    end
    bus.req_valid = '0;
    tick();
    chk("arb_idle", bus.busy, 0);

    // Reset during the second byte of a 4-byte write.
    set_req(0, 1'b1, 32'h200, 32'h01020304, 3'd4, 1'b0);
    tick();
    chk("rstw_grant", bus.grant, 2'b01);
    tick();
    chk("rstw_rw_before", bus.ram_rw, 1);
    chk("rstw_addr_before", bus.ram_addr, 32'h201);
    #2 reset = 1'b0;
    #1;
    chk("rstw_rw_async", bus.ram_rw, 0);
    chk("rstw_grant_async", bus.grant, 0);
    chk("rstw_busy_async", bus.busy, 0);
    bus.req_valid = '0;
    done_acc = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      done_acc = done_acc | bus.resp_done;
    end
    chk("rstw_no_done", done_acc, 0);
    reset = 1'b1;
    tick();

    // Fresh read after reset release.
    set_req(1, 1'b0, 32'h100, 32'h0, 3'd4, 1'b0);
    wait_done(1'b0);
    chk("post_rst_done", o_done, 2'b10);
    chk("post_rst_data", o_data, 32'h44332211);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
